// File: rtl/nn_pkg.sv
// Shared definitions for the MAC neuron: FSM state encoding and default widths.
package nn_pkg;

    localparam int DEFAULT_DATA_W = 16;
    localparam int DEFAULT_SUM_W  = 24;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        ACT  = 2'd2,
        HOLD = 2'd3
    } state_t;

endpackage

// File: rtl/nn_mac_step.sv
// One combinational multiply-accumulate step: o_acc = i_acc + i_x * i_w.
// Build option NN_MAC_SATURATE_EN: clamp the result to the signed SUM_W range
// and raise o_sat when the clamp engages. Without it the add wraps and o_sat is 0.
module nn_mac_step
#(
    parameter int DATA_W = 16,
    parameter int SUM_W  = 24
) (
    input  logic signed [DATA_W-1:0] i_x,
    input  logic signed [DATA_W-1:0] i_w,
    input  logic signed [SUM_W-1:0]  i_acc,
    output logic signed [SUM_W-1:0]  o_acc,
    output logic                     o_sat
);

`ifdef NN_MAC_SATURATE_EN
    // Wide enough to hold the exact product plus accumulator without overflow.
    localparam int CALC_W = ((SUM_W > 2*DATA_W) ? SUM_W : 2*DATA_W) + 1;

    localparam logic signed [CALC_W-1:0] SUM_MAX =
        {{(CALC_W-SUM_W+1){1'b0}}, {(SUM_W-1){1'b1}}};
    localparam logic signed [CALC_W-1:0] SUM_MIN =
        {{(CALC_W-SUM_W+1){1'b1}}, {(SUM_W-1){1'b0}}};

    logic signed [CALC_W-1:0] w_x_ext;
    logic signed [CALC_W-1:0] w_w_ext;
    logic signed [CALC_W-1:0] w_acc_ext;
    logic signed [CALC_W-1:0] w_sum;

    assign w_x_ext   = {{(CALC_W-DATA_W){i_x[DATA_W-1]}}, i_x};
    assign w_w_ext   = {{(CALC_W-DATA_W){i_w[DATA_W-1]}}, i_w};
    assign w_acc_ext = {{(CALC_W-SUM_W){i_acc[SUM_W-1]}}, i_acc};
    assign w_sum     = w_acc_ext + w_x_ext * w_w_ext;

    // Clamp the exact sum into the accumulator range.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        o_acc = w_sum[SUM_W-1:0];
        o_sat = 1'b0;
        if (w_sum > SUM_MAX) begin
            o_acc = SUM_MAX[SUM_W-1:0];
            o_sat = 1'b1;
        end else if (w_sum < SUM_MIN) begin
            o_acc = SUM_MIN[SUM_W-1:0];
            o_sat = 1'b1;
        end
    end
`else
    // Operands extended to SUM_W: the product is then exact modulo 2^SUM_W.
    logic signed [SUM_W-1:0] w_x_ext;
    logic signed [SUM_W-1:0] w_w_ext;

    assign w_x_ext = {{(SUM_W-DATA_W){i_x[DATA_W-1]}}, i_x};
    assign w_w_ext = {{(SUM_W-DATA_W){i_w[DATA_W-1]}}, i_w};
    assign o_acc   = i_acc + w_x_ext * w_w_ext;
    assign o_sat   = 1'b0;
`endif

endmodule

// File: rtl/nn_mac_neuron.sv
// Sequential MAC neuron: accepts an operand set, accumulates one product per
// cycle starting from the bias, then presents a thresholded decision and the
// pre-activation sum until the consumer takes it.
// Build option NN_MAC_SATURATE_EN: saturating accumulation with sticky sat flag.
module nn_mac_neuron
    import nn_pkg::*;
#(
    parameter int N_INPUTS = 4,
    parameter int DATA_W   = DEFAULT_DATA_W,
    parameter int SUM_W    = DEFAULT_SUM_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [N_INPUTS*DATA_W-1:0] x_vec,
    input  logic [N_INPUTS*DATA_W-1:0] w_vec,
    input  logic [DATA_W-1:0]          bias,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       out,
    output logic [SUM_W-1:0]           sum,
    output logic                       sat
);

    localparam int                IDX_W    = $clog2(N_INPUTS);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(N_INPUTS - 1);

    state_t                    r_state;
    state_t                    w_next_state;
    logic                      w_accept;

    logic signed [DATA_W-1:0]  r_x [N_INPUTS];
    logic signed [DATA_W-1:0]  r_w [N_INPUTS];
    logic [IDX_W-1:0]          r_idx;
    logic signed [SUM_W-1:0]   r_acc;
    logic                      r_acc_sat;
    logic                      r_out;
    logic [SUM_W-1:0]          r_sum;
    logic                      r_sat;

    logic signed [SUM_W-1:0]   w_step_acc;
    logic                      w_step_sat;

    assign w_accept = in_ready && in_valid;

    // State register; reset wins over any handshake in the same cycle.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) r_state <= IDLE;
        else     r_state <= w_next_state;
    end

    // Next-state decision.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (in_valid)           w_next_state = ACC;
            ACC:     if (r_idx == LAST_IDX)  w_next_state = ACT;
            ACT:                             w_next_state = HOLD;
            HOLD:    if (out_ready)          w_next_state = IDLE;
            default:                         w_next_state = IDLE;
        endcase
    end

    // Handshake outputs decoded from the current state.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            IDLE:    in_ready  = 1'b1;
            HOLD:    out_valid = 1'b1;
            default: ;
        endcase
    end

    // Operand capture on the accepting edge only.
    always_ff @(posedge clk) begin
        // NOTE: operand registers carry no reset; they are only read in ACC, after a load.
        if (!rst && w_accept) begin
            for (int i = 0; i < N_INPUTS; i++) begin
                r_x[i] <= x_vec[i*DATA_W +: DATA_W];
                r_w[i] <= w_vec[i*DATA_W +: DATA_W];
            end
        end
    end

    nn_mac_step #(
        .DATA_W (DATA_W),
        .SUM_W  (SUM_W)
    ) u_step (
        .i_x   (r_x[r_idx]),
        .i_w   (r_w[r_idx]),
        .i_acc (r_acc),
        .o_acc (w_step_acc),
        .o_sat (w_step_sat)
    );

    // Accumulator, index and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx     <= '0;
            r_acc     <= '0;
            r_acc_sat <= 1'b0;
            r_out     <= 1'b0;
            r_sum     <= '0;
            r_sat     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_acc     <= {{(SUM_W-DATA_W){bias[DATA_W-1]}}, bias};
                        r_idx     <= '0;
                        r_acc_sat <= 1'b0;
                    end
                end
                ACC: begin
                    r_acc     <= w_step_acc;
                    r_acc_sat <= r_acc_sat | w_step_sat;
                    r_idx     <= (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
                end
                ACT: begin
                    // Strictly positive fires; zero does not.
                    r_out <= !r_acc[SUM_W-1] && (r_acc != '0);
                    r_sum <= r_acc;
                    r_sat <= r_acc_sat;
                end
                default: ;
            endcase
        end
    end

    assign out = r_out;
    assign sum = r_sum;
    assign sat = r_sat;

endmodule

// File: tb/tb_nn_mac_neuron.sv
// Scoreboard bench for nn_mac_neuron: a 2-input and a 4-input instance.
// Drivers push hand-computed expectations; a negedge monitor pops and compares.
// Expected values for the wide-sum vectors depend on NN_MAC_SATURATE_EN.
module tb_nn_mac_neuron;

    localparam int DW = 16;
    localparam int SW = 24;

    typedef struct {
        longint sum;
        bit     out;
        bit     sat;
        int     acc_edge;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // 2-input instance
    logic                 in_valid2, in_ready2, out_valid2, ready2, out2, sat2;
    logic [2*DW-1:0]      x2, w2;
    logic [DW-1:0]        bias2;
    logic signed [SW-1:0] sum2;

    // 4-input instance
    logic                 in_valid4, in_ready4, out_valid4, ready4, out4, sat4;
    logic [4*DW-1:0]      x4, w4;
    logic [DW-1:0]        bias4;
    logic signed [SW-1:0] sum4;

    exp_t q2[$];
    exp_t q4[$];
    bit   seen[2];
    bit   prev_hs[2];

    nn_mac_neuron #(.N_INPUTS(2), .DATA_W(DW), .SUM_W(SW)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
        .x_vec(x2), .w_vec(w2), .bias(bias2), .out_valid(out_valid2),
        .out_ready(ready2), .out(out2), .sum(sum2), .sat(sat2)
    );

    nn_mac_neuron #(.N_INPUTS(4), .DATA_W(DW), .SUM_W(SW)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
        .x_vec(x4), .w_vec(w4), .bias(bias4), .out_valid(out_valid4),
        .out_ready(ready4), .out(out4), .sum(sum4), .sat(sat4)
    );

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic monitor(input int which, input int n, input logic valid, input logic ready,
                           input logic in_rdy, input longint s, input logic o, input logic st);
        exp_t  e;
        int    depth;
        string tag;
        tag   = (which == 0) ? "n2" : "n4";
        depth = (which == 0) ? q2.size() : q4.size();
        if (prev_hs[which]) check({tag, "_valid_one_cycle"}, valid, 0);
        if (valid) begin
            if (depth == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL %s_unexpected: out_valid=1 with nothing pending, sum=%0d", tag, s);
            end else begin
                e = (which == 0) ? q2[0] : q4[0];
                if (!seen[which]) begin
                    seen[which] = 1'b1;
                    check({tag, "_latency"}, cyc - e.acc_edge, n + 1);
                end
                check({tag, "_sum"}, s, e.sum);
                check({tag, "_out"}, o, e.out);
                check({tag, "_sat"}, st, e.sat);
                check({tag, "_in_ready_busy"}, in_rdy, 0);
                if (ready) begin
                    if (which == 0) void'(q2.pop_front());
                    else            void'(q4.pop_front());
                    seen[which] = 1'b0;
                end
            end
        end
        prev_hs[which] = valid && ready;
    endtask

    // Monitor: compares whenever a DUT presents a result.
    always @(negedge clk) begin
        if (rst) begin
            seen    = '{default: 1'b0};
            prev_hs = '{default: 1'b0};
        end else begin
            monitor(0, 2, out_valid2, ready2, in_ready2, sum2, out2, sat2);
            monitor(1, 4, out_valid4, ready4, in_ready4, sum4, out4, sat4);
        end
    end

    task automatic accept2(input int x0, input int x1, input int w0, input int w1,
                           input int b, output int acc_edge);
        @(posedge clk); #1;
        x2 = {DW'(x1), DW'(x0)};
        w2 = {DW'(w1), DW'(w0)};
        bias2 = DW'(b);
        in_valid2 = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 100 && !in_ready2; k++) @(negedge clk);
        if (!in_ready2) begin
            n_checks++;
            n_fail++;
            $display("FAIL n2_accept_timeout: in_ready=0, expected 1");
        end
        acc_edge = cyc + 1;
        @(posedge clk); #1;
        in_valid2 = 1'b0;
        x2 = 32'h7FFF_8001;
        w2 = 32'h8000_7FFF;
        bias2 = 16'h7FFF;
    endtask

    task automatic send2(input int x0, input int x1, input int w0, input int w1, input int b,
                         input longint exp_sum, input bit exp_out);
        exp_t e;
        int   ae;
        accept2(x0, x1, w0, w1, b, ae);
        e.sum = exp_sum; e.out = exp_out; e.sat = 1'b0; e.acc_edge = ae;
        q2.push_back(e);
    endtask

    task automatic send4(input logic [4*DW-1:0] xv, input logic [4*DW-1:0] wv, input int b,
                         input longint exp_sum, input bit exp_out, input bit exp_sat);
        exp_t e;
        @(posedge clk); #1;
        x4 = xv; w4 = wv; bias4 = DW'(b); in_valid4 = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 100 && !in_ready4; k++) @(negedge clk);
        if (!in_ready4) begin
            n_checks++;
            n_fail++;
            $display("FAIL n4_accept_timeout: in_ready=0, expected 1");
        end
        e.sum = exp_sum; e.out = exp_out; e.sat = exp_sat; e.acc_edge = cyc + 1;
        @(posedge clk); #1;
        q4.push_back(e);
        in_valid4 = 1'b0;
        x4 = '1;
        w4 = '0;
        bias4 = 16'h8000;
    endtask

    task automatic drain();
        for (int k = 0; k < 300 && (q2.size() != 0 || q4.size() != 0); k++) @(negedge clk);
        check("drain_pending", q2.size() + q4.size(), 0);
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int ae;
        rst = 1'b1;
        in_valid2 = 1'b0; x2 = '0; w2 = '0; bias2 = '0; ready2 = 1'b1;
        in_valid4 = 1'b0; x4 = '0; w4 = '0; bias4 = '0; ready4 = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_in_ready", in_ready2, 1);
        check("rst_out_valid", out_valid2, 0);
        check("rst_out", out2, 0);
        check("rst_sum", sum2, 0);
        check("rst_sat", sat2, 0);
        check("rst_in_ready4", in_ready4, 1);

        // Basic AND-like neuron, then the other input patterns back to back
        send2(1, 1, 20, 20, -30, 10, 1'b1);
        drain();
        send2(1, 0, 20, 20, -30, -10, 1'b0);
        send2(0, 1, 20, 20, -30, -10, 1'b0);
        send2(0, 0, 20, 20, -30, -30, 1'b0);
        send2(1, 1, 15, 15, -30, 0, 1'b0);
        send2(-3, 7, -100, 2, 5, 319, 1'b1);
        drain();

        // Backpressure: hold the result, offer a new operand set meanwhile
        @(posedge clk); #1 ready2 = 1'b0;
        send2(2, 3, 4, 5, 1, 24, 1'b1);
        for (int k = 0; k < 50 && !out_valid2; k++) @(negedge clk);
        check("bp_out_valid_seen", out_valid2, 1);
        @(posedge clk); #1;
        in_valid2 = 1'b1; x2 = {16'sd9, 16'sd9}; w2 = {16'sd9, 16'sd9}; bias2 = 16'sd9;
        repeat (4) @(posedge clk);
        #1;
        check("bp_in_ready_held", in_ready2, 0);
        in_valid2 = 1'b0;
        ready2 = 1'b1;
        drain();
        send2(4, -2, 10, 10, -25, -5, 1'b0);
        drain();

        // Reset during the second ACC cycle discards the transaction
        accept2(5, 5, 20, 20, -30, ae);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("midrst_in_ready", in_ready2, 1);
        check("midrst_out_valid", out_valid2, 0);
        repeat (6) @(negedge clk);
        check("midrst_no_output", out_valid2, 0);
        send2(1, 1, 20, 20, -30, 10, 1'b1);
        drain();

        // 4-input instance: accumulator range boundaries
`ifdef NN_MAC_SATURATE_EN
        send4({4{16'sd32767}}, {4{16'sd32767}}, 0, 8388607, 1'b1, 1'b1);
        send4({4{-16'sd32768}}, {4{16'sd32767}}, 0, -8388608, 1'b0, 1'b1);
`else
        send4({4{16'sd32767}}, {4{16'sd32767}}, 0, -262140, 1'b0, 1'b0);
        send4({4{-16'sd32768}}, {4{16'sd32767}}, 0, 131072, 1'b1, 1'b0);
`endif
        send4({16'sd4, 16'sd3, 16'sd2, 16'sd1}, {-16'sd8, 16'sd7, -16'sd6, 16'sd5}, 3, -15, 1'b0, 1'b0);
        send4('0, '0, 1, 1, 1'b1, 1'b0);
        send4('0, '0, -1, -1, 1'b0, 1'b0);
        drain();

        check("final_q2_empty", q2.size(), 0);
        check("final_q4_empty", q4.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
